mu0_mem_arbiter: RTL and testbench
==================================

# mu0_mem_arbiter

Two-port round-robin arbiter that shares one synchronous MU0 memory (12-bit word address, 16-bit data) between two bus requesters, e.g. two MU0 CPUs, or one CPU plus a loader/debug master. Each requester sees a waitrequest/readdatavalid bus. The arbiter grants at most one access per cycle, forwards it to the memory port in the same cycle, and tags each read so its data returns only to the issuer after a fixed memory latency.

## Interface
- READ_LATENCY, 1: cycles from the accepting edge to mem_readdata valid; legal range 1–4.
- ADDR_WIDTH, 12: word address width.
- DATA_WIDTH, 16: data width.

Ports:
- clk  in  1  single clock; all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_address  in  [1:0][ADDR_WIDTH-1:0]  per-requester address.
- req_read  in  [1:0]  read request.
- req_write  in  [1:0]  write request.
- req_writedata  in  [1:0][DATA_WIDTH-1:0]  write data.
- req_waitrequest  out  [1:0]  1 = not accepted this cycle; requester must hold its command.
- req_readdata  out  [DATA_WIDTH-1:0]  shared return data; qualified by req_readdatavalid.
- req_readdatavalid  out  [1:0]  one-hot; read data for that requester is valid this cycle.
- mem_address  out  ADDR_WIDTH  address to memory.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_writedata  out  DATA_WIDTH  write data to memory.
- mem_readdata  in  DATA_WIDTH  memory read data, READ_LATENCY cycles after the strobe edge.

## Operation
- Requester i is active when req_read[i] | req_write[i]. If both are set, the access is a write and the read is ignored. The bench flags this case as a protocol error.
- Grant is combinational on active requests and a registered priority pointer prio (0/1).
  - One requester active: it wins.
  - Both active: requester prio wins.
  - Neither active: no grant.
- The granted command drives mem_* directly.
- With no grant: mem_read = mem_write = 0, mem_address = 0, mem_writedata = 0.
- req_waitrequest[i] = ~granted[i]. It is 1 for an idle requester too.
- On a grant to i, prio <= ~i at the edge. prio is unchanged when there is no grant. A requester that loses therefore wins the next contested cycle; there is no starvation.
- Read tag pipeline: READ_LATENCY stages of {valid, id}. Stage 0 loads {granted read, winner id}; stages shift every cycle.
  - When the last stage is valid: req_readdatavalid[id] = 1 and req_readdata = mem_readdata.
  - Otherwise req_readdatavalid = 0 and req_readdata = 0.
- Writes produce no return.
- Reads and writes pipeline freely at one access per cycle. A write may follow a read in the next cycle to the same address; ordering to the memory is issue order.

## Timing
- Reset (async assert, deasserted synchronously by the system): prio = 0, all tag stages invalid.
  - While rst = 1: no grants, req_waitrequest = 2'b11, mem_read = mem_write = 0, req_readdatavalid = 0.
- Acceptance occurs at the rising edge of a cycle with req_waitrequest[i] = 0. The requester may change its command in the next cycle.
- Read latency seen by the requester: readdatavalid is high in the cycle that begins READ_LATENCY edges after acceptance. With latency 1, that is the cycle immediately after acceptance.
- Throughput: 1 access/cycle aggregate. Two continuously requesting masters each get exactly 1 of every 2 cycles.
- Reset mid-operation: in-flight reads are discarded. No readdatavalid pulse occurs after rst asserts until a new read is accepted.
- A requester dropping its request while waiting is legal. No access is generated for it.

## Structure
- Package mu0_bus_pkg holds:
  - ADDR_WIDTH and DATA_WIDTH localparams (12/16).
  - typedef req_id_t (logic, 1 bit).
  - A typedef for the read tag {valid, req_id_t}.
- Sub-module mu0_rd_tag_pipe:
  - Parameterised depth, async reset, shift register of tags.
  - Output is the last stage.
- The top level contains the grant logic, prio register, muxes and readdata steering.

## Test plan
- Single requester: r0 reads address 0x005 with memory holding 0x1234, READ_LATENCY = 1 → waitrequest[0] = 0 in the same cycle, mem_address = 0x005, next cycle readdatavalid = 2'b01 with data 0x1234.
- Contention: both read every cycle from reset → grants alternate r0, r1, r0, r1; readdatavalid alternates 01/10 with the matching data; prio toggles each cycle.
- Mixed: r0 writes 0xBEEF to 0x010 while r1 reads 0x010 in the same cycle, prio = 0 → r0 is granted first, r1 in the next cycle, and r1 receives 0xBEEF.
- READ_LATENCY = 3 with back-to-back reads r1 at 0x001, 0x002, 0x003 → readdatavalid[1] is high on three consecutive cycles starting 3 cycles after the first acceptance, in order.
- Reset mid-flight: with READ_LATENCY = 3, a read is accepted, then rst pulses 1 cycle later → no readdatavalid ever appears for it; prio = 0 after reset.
- Idle/illegal: no requests → mem_read = mem_write = 0, waitrequest = 11. r0 with read = write = 1 → a write is issued and no readdatavalid follows.

Source files
------------

// File: rtl/mu0_bus_pkg.sv
// Shared types for the MU0 memory bus: widths, requester id and the read tag
// that follows an accepted read through the memory latency.
package mu0_bus_pkg;

    localparam int ADDR_WIDTH = 12;
    localparam int DATA_WIDTH = 16;

    typedef logic req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } rd_tag_t;

endpackage

// File: rtl/mu0_rd_tag_pipe.sv
// Fixed-depth shift register of read tags; the last stage lines up with the
// cycle in which memory read data is valid.
module mu0_rd_tag_pipe
    import mu0_bus_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clk,
    input  logic    rst,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t [DEPTH-1:0] tag_q;
    rd_tag_t [DEPTH-1:0] tag_d;

    always_comb begin
        tag_d    = tag_q;
        tag_d[0] = tag_in;
        for (int s = 1; s < DEPTH; s++) begin
            tag_d[s] = tag_q[s-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q <= '0;
        end else begin
            tag_q <= tag_d;
        end
    end

    assign tag_out = tag_q[DEPTH-1];

endmodule

// File: rtl/mu0_mem_arbiter.sv
// Two-requester round-robin arbiter in front of one synchronous MU0 memory.
// Grants at most one access per cycle and steers read data back by tag.
module mu0_mem_arbiter #(
    parameter int READ_LATENCY = 1,
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0][ADDR_WIDTH-1:0] req_address,
    input  logic [1:0]                 req_read,
    input  logic [1:0]                 req_write,
    input  logic [1:0][DATA_WIDTH-1:0] req_writedata,
    output logic [1:0]                 req_waitrequest,
    output logic [DATA_WIDTH-1:0]      req_readdata,
    output logic [1:0]                 req_readdatavalid,
    output logic [ADDR_WIDTH-1:0]      mem_address,
    output logic                       mem_read,
    output logic                       mem_write,
    output logic [DATA_WIDTH-1:0]      mem_writedata,
    input  logic [DATA_WIDTH-1:0]      mem_readdata
);

    import mu0_bus_pkg::*;

    logic [1:0] active;
    logic [1:0] granted;
    logic       gnt_vld;
    req_id_t    win;
    logic       prio_q;
    logic       prio_d;
    rd_tag_t    tag_in;
    rd_tag_t    tag_out;

    // Nothing is granted while reset is held, even to a requester already asserting.
    assign active = (req_read | req_write) & {2{~rst}};

    always_comb begin
        gnt_vld       = |active;
        win           = prio_q;
        granted       = 2'b00;
        mem_address   = '0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_writedata = '0;
        prio_d        = prio_q;
        if (active == 2'b01) begin
            win = 1'b0;
        end else if (active == 2'b10) begin
            win = 1'b1;
        end
        if (gnt_vld) begin
            granted[win]  = 1'b1;
            mem_address   = req_address[win];
            mem_write     = req_write[win];
            mem_read      = req_read[win] & ~req_write[win];
            mem_writedata = req_writedata[win];
            prio_d        = ~win;
        end
    end

    assign req_waitrequest = ~granted;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

    assign tag_in = '{valid: mem_read, id: win};

    mu0_rd_tag_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    always_comb begin
        req_readdatavalid = 2'b00;
        req_readdata      = '0;
        if (tag_out.valid) begin
            req_readdatavalid[tag_out.id] = 1'b1;
            req_readdata                  = mem_readdata;
        end
    end

endmodule

// File: tb/tb_mu0_mem_arbiter.sv
// Bench for mu0_mem_arbiter: two DUTs (read latency 1 and 3) share the same
// request stimulus; each has its own memory model and return-data scoreboard.
module tb_mu0_mem_arbiter;

    typedef struct {
        logic        id;
        logic [15:0] d;
        int          due;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       req_read = '0;
    logic [1:0]       req_write = '0;
    logic [1:0][11:0] req_address = '0;
    logic [1:0][15:0] req_writedata = '0;
    logic [15:0]      exp_rd [2];

    logic [1:0]  wait_o [2];
    logic [15:0] rdata_o [2];
    logic [1:0]  rdv_o [2];
    logic [11:0] maddr [2];
    logic        mrd [2];
    logic        mwr [2];
    logic [15:0] mwd [2];
    logic [15:0] mrdata [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g
        localparam int LAT = (k == 0) ? 1 : 3;
        exp_t        q[$];
        logic [15:0] mem [4096];
        logic [15:0] pipe [LAT];

        mu0_mem_arbiter #(.READ_LATENCY(LAT)) dut (
            .clk               (clk),
            .rst               (rst),
            .req_address       (req_address),
            .req_read          (req_read),
            .req_write         (req_write),
            .req_writedata     (req_writedata),
            .req_waitrequest   (wait_o[k]),
            .req_readdata      (rdata_o[k]),
            .req_readdatavalid (rdv_o[k]),
            .mem_address       (maddr[k]),
            .mem_read          (mrd[k]),
            .mem_write         (mwr[k]),
            .mem_writedata     (mwd[k]),
            .mem_readdata      (mrdata[k])
        );

        initial begin
            for (int a = 0; a < 4096; a++) mem[a] = 16'hA000 | 16'(a);
            mem[5] = 16'h1234;
        end

        // Memory model; non-read cycles return a marker so mis-steered data shows up.
        always @(posedge clk) begin
            pipe[0] <= mrd[k] ? mem[maddr[k]] : 16'hDEAD;
            for (int j = 1; j < LAT; j++) pipe[j] <= pipe[j-1];
            if (mwr[k]) mem[maddr[k]] = mwd[k];
        end
        assign mrdata[k] = pipe[LAT-1];

        initial begin
            int   ncyc;
            exp_t e;
            ncyc = 0;
            forever begin
                @(negedge clk);
                ncyc++;
                if (rst) begin
                    q.delete();
                    chk($sformatf("L%0d rdv in reset", LAT), {14'd0, rdv_o[k]}, 0);
                end else begin
                    if (q.size() > 0 && q[0].due == ncyc) begin
                        e = q.pop_front();
                        chk($sformatf("L%0d rdv id%0d", LAT, e.id), {14'd0, rdv_o[k]}, e.id ? 2 : 1);
                        chk($sformatf("L%0d rdata id%0d", LAT, e.id), {16'd0, rdata_o[k]}, {16'd0, e.d});
                    end else begin
                        chk($sformatf("L%0d idle rdv/rdata", LAT), {rdv_o[k], rdata_o[k]}, 0);
                    end
                    for (int i = 0; i < 2; i++) begin
                        if (!wait_o[k][i] && req_read[i] && !req_write[i])
                            q.push_back('{id: 1'(i), d: exp_rd[i], due: ncyc + LAT});
                    end
                end
            end
        end
    end

    // One cycle of stimulus, then check the combinational grant against ew/ea.
    task automatic vec(input logic [1:0] rd, input logic [1:0] wr,
                       input logic [11:0] a0, input logic [11:0] a1,
                       input logic [15:0] d0, input logic [15:0] d1,
                       input logic [15:0] e0, input logic [15:0] e1,
                       input logic [1:0] ew, input logic [11:0] ea, input string nm);
        int w;
        @(posedge clk);
        #2;
        req_read = rd;
        req_write = wr;
        req_address[0] = a0;
        req_address[1] = a1;
        req_writedata[0] = d0;
        req_writedata[1] = d1;
        exp_rd[0] = e0;
        exp_rd[1] = e1;
        #1;
        w = ew[0] ? 1 : 0;
        for (int k = 0; k < 2; k++) begin
            chk({nm, " wait"}, {30'd0, wait_o[k]}, {30'd0, ew});
            chk({nm, " addr"}, {20'd0, maddr[k]}, {20'd0, ea});
            if (ew == 2'b11) begin
                chk({nm, " rd/wr"}, {30'd0, mrd[k], mwr[k]}, 0);
            end else begin
                chk({nm, " rd/wr"}, {30'd0, mrd[k], mwr[k]}, {30'd0, rd[w] & ~wr[w], wr[w]});
                if (wr[w]) chk({nm, " wdata"}, {16'd0, mwd[k]}, {16'd0, (w == 1) ? d1 : d0});
            end
        end
    endtask

    initial begin
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        req_read = 2'b01;
        req_address[0] = 12'h005;
        #3;
        for (int k = 0; k < 2; k++) begin
            chk("reset wait", {30'd0, wait_o[k]}, 3);
            chk("reset rd/wr", {30'd0, mrd[k], mwr[k]}, 0);
            chk("reset rdv", {30'd0, rdv_o[k]}, 0);
        end
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        req_read = 2'b00;

        vec(2'b01, 2'b00, 12'h005, 12'h000, 16'h0, 16'h0, 16'h1234, 16'h0, 2'b10, 12'h005, "single r0");
        vec(2'b00, 2'b00, 12'h000, 12'h000, 16'h0, 16'h0, 16'h0, 16'h0, 2'b11, 12'h000, "idle");
        vec(2'b01, 2'b01, 12'h020, 12'h000, 16'h5555, 16'h0, 16'h0, 16'h0, 2'b10, 12'h020, "rd+wr r0");
        vec(2'b10, 2'b00, 12'h000, 12'h003, 16'h0, 16'h0, 16'h0, 16'hA003, 2'b01, 12'h003, "single r1");
        vec(2'b10, 2'b01, 12'h010, 12'h010, 16'hBEEF, 16'h0, 16'h0, 16'hBEEF, 2'b10, 12'h010, "mixed wr r0");
        vec(2'b10, 2'b00, 12'h000, 12'h010, 16'h0, 16'h0, 16'h0, 16'hBEEF, 2'b01, 12'h010, "mixed rd r1");
        vec(2'b10, 2'b00, 12'h000, 12'h001, 16'h0, 16'h0, 16'h0, 16'hA001, 2'b01, 12'h001, "b2b r1 a");
        vec(2'b10, 2'b00, 12'h000, 12'h002, 16'h0, 16'h0, 16'h0, 16'hA002, 2'b01, 12'h002, "b2b r1 b");
        vec(2'b10, 2'b00, 12'h000, 12'h003, 16'h0, 16'h0, 16'h0, 16'hA003, 2'b01, 12'h003, "b2b r1 c");
        vec(2'b01, 2'b00, 12'h020, 12'h000, 16'h0, 16'h0, 16'h5555, 16'h0, 2'b10, 12'h020, "readback r0");
        vec(2'b01, 2'b00, 12'h005, 12'h000, 16'h0, 16'h0, 16'h1234, 16'h0, 2'b10, 12'h005, "pre-reset r0");

        @(posedge clk);
        #2;
        rst = 1'b1;
        req_read = 2'b00;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("midrst wait", {30'd0, wait_o[k]}, 3);
            chk("midrst rdv", {30'd0, rdv_o[k]}, 0);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;

        for (int n = 0; n < 4; n++) begin
            vec(2'b11, 2'b00, 12'h005, 12'h001, 16'h0, 16'h0, 16'h1234, 16'hA001,
                (n % 2 == 0) ? 2'b10 : 2'b01, (n % 2 == 0) ? 12'h005 : 12'h001, "contend");
        end
        for (int n = 0; n < 5; n++) begin
            vec(2'b00, 2'b00, 12'h000, 12'h000, 16'h0, 16'h0, 16'h0, 16'h0, 2'b11, 12'h000, "drain");
        end
        chk("L1 outstanding", g[0].q.size(), 0);
        chk("L3 outstanding", g[1].q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
